// File: rtl/score_row_max.sv
// Row-maximum stage: captures one LANES-wide fp32 score row, scans it one lane
// per cycle for the NaN-aware maximum, then offers row/max/index via valid/ready.
module score_row_max #(
    parameter int LANES = 16,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LANES*32-1:0]   scaled_score,
    output logic [LANES*32-1:0]   score_out,
    output logic [31:0]           max_score,
    output logic [IDX_W-1:0]      max_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);
    localparam logic [31:0]      QNAN = 32'h7FC0_0000;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t                state_q, state_d;
    logic [LANES*32-1:0]   row_q, row_d;
    logic [31:0]           best_q, best_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  have_q, have_d;
    logic                  start_q;
    logic                  overrun_q, overrun_d;
    logic                  start_rise;
    logic [31:0]           lane;
    logic                  lane_wins;

    function automatic logic is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key; -0 folded onto +0 so the two compare equal.
    function automatic logic [31:0] fp_key(input logic [31:0] b);
        logic [31:0] n;
        n = (b == 32'h8000_0000) ? 32'd0 : b;
        return n[31] ? ~n : {1'b1, n[30:0]};
    endfunction

    assign start_rise = start & ~start_q;
    assign lane       = row_q[32*cnt_q +: 32];
    // have_q is low while best still holds a NaN lane 0, so any real lane wins.
    assign lane_wins  = !is_nan(lane) && (!have_q || (fp_key(lane) > fp_key(best_q)));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        best_d    = best_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        have_d    = have_q;
        overrun_d = overrun_q | (start_rise && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    row_d   = scaled_score;
                    best_d  = scaled_score[31:0];
                    idx_d   = '0;
                    cnt_d   = IDX_W'(1);
                    have_d  = !is_nan(scaled_score[31:0]);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (lane_wins) begin
                    best_d = lane;
                    idx_d  = cnt_q;
                    have_d = 1'b1;
                end
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST) begin
                    state_d = HOLD;
                    if (!have_d) begin
                        best_d = QNAN;
                        idx_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            best_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            have_q    <= 1'b0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            best_q    <= best_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            have_q    <= have_d;
            start_q   <= start;
            overrun_q <= overrun_d;
        end
    end

    assign score_out = row_q;
    assign max_score = best_q;
    assign max_idx   = idx_q;
    assign out_valid = (state_q == HOLD);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_score_row_max.sv
// Scoreboard bench for score_row_max: rows are pushed with a real-valued
// reference maximum, and a monitor compares every cycle the DUT offers a result.
module tb_score_row_max;
    localparam int LANES = 16;
    localparam int W     = LANES * 32;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [W-1:0] row;
        logic [31:0]  mx;
        logic [3:0]   idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] scaled_score = '0;
    logic [W-1:0] score_out;
    logic [31:0]  max_score;
    logic [3:0]   max_idx;
    logic         out_valid;
    logic         overrun;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;

    always #5 clk = ~clk;

    score_row_max #(.LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .scaled_score (scaled_score),
        .score_out    (score_out),
        .max_score    (max_score),
        .max_idx      (max_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkRow(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Numeric value of an fp32 pattern; infinities become huge reals that still order correctly.
    function automatic real fpVal(input logic [31:0] b);
        int  e;
        real v;
        e = int'(b[30:23]);
        if (e == 255)
            v = 1.0e300;
        else if (e == 0)
            v = real'(b[22:0]) * (2.0 ** (-149));
        else
            v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic exp_t refModel(input logic [W-1:0] row);
        exp_t        e;
        int          best;
        real         bv;
        real         v;
        logic [31:0] ln;
        best = -1;
        bv   = 0.0;
        for (int i = 0; i < LANES; i++) begin
            ln = row[i*32 +: 32];
            if (!(ln[30:23] == 8'hFF && ln[22:0] != 23'd0)) begin
                v = fpVal(ln);
                if (best < 0 || v > bv) begin
                    best = i;
                    bv   = v;
                end
            end
        end
        e.row = row;
        if (best < 0) begin
            e.mx  = QNAN;
            e.idx = 4'd0;
        end else begin
            e.mx  = row[best*32 +: 32];
            e.idx = 4'(best);
        end
        return e;
    endfunction

    function automatic logic [31:0] intToFp(input int i);
        int e;
        if (i == 0) return 32'd0;
        e = $clog2(i + 1) - 1;
        return {1'b0, 8'(127 + e), 23'((i - (1 << e)) << (23 - e))};
    endfunction

    function automatic logic [31:0] randLane();
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       return {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 8388607))};
            1:       return {$urandom_range(0, 1) == 1, 8'hFF, 23'd0};
            2:       return {$urandom_range(0, 1) == 1, 31'd0};
            3:       return {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom_range(1, 8388607))};
            default: return {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic waitValid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Issues a one-cycle start with row, checks latency, then accepts after hold cycles.
    task automatic applyStimulus(input logic [W-1:0] row, input int hold);
        int cyc;
        scaled_score = row;
        start = 1'b1;
        sb.push_back(refModel(row));
        @(posedge clk);
        #1;
        start = 1'b0;
        scaled_score = '0;
        waitValid(cyc);
        checkOutput("latency", 32'(cyc), 32'(LANES - 1));
        if (!out_valid) begin
            sb.delete();
            return;
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin : monitor
        logic acc_prev;
        exp_t e;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc_prev = 1'b0;
            end else begin
                if (acc_prev) checkOutput("valid_drop", 32'(out_valid), 32'd0);
                acc_prev = 1'b0;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_result: got out_valid=1 expected no pending row");
                    end else begin
                        e = sb[0];
                        checkRow("score_out", score_out, e.row);
                        checkOutput("max_score", max_score, e.mx);
                        checkOutput("max_idx", 32'(max_idx), 32'(e.idx));
                        if (out_ready) begin
                            void'(sb.pop_front());
                            acc_prev = 1'b1;
                            n_acc++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected test completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin : stim
        logic [W-1:0] row;
        int           cyc;
        int           n0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_max", max_score, 32'd0);
        checkOutput("rst_idx", 32'(max_idx), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkRow("rst_score", score_out, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] ramp row");
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = intToFp(i);
        applyStimulus(row, 0);

        $display("[TB] tie row");
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = 32'h3F80_0000;
        row[3*32 +: 32] = 32'h40A0_0000;
        row[9*32 +: 32] = 32'h40A0_0000;
        applyStimulus(row, 1);

        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = 32'hBF80_0000;
        row[7*32 +: 32] = 32'hBF00_0000;
        applyStimulus(row, 0);

        $display("[TB] NaN rows");
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = 32'hC100_0000;
        row[31:0] = 32'h7FC0_0000;
        row[5*32 +: 32] = 32'hC000_0000;
        applyStimulus(row, 0);

        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = {i[0], 8'hFF, 23'(i + 1)};
        applyStimulus(row, 0);

        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = 32'hC040_0000;
        row[2*32 +: 32] = 32'h8000_0000;
        row[4*32 +: 32] = 32'h0000_0000;
        applyStimulus(row, 0);

        $display("[TB] stall in HOLD");
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
        applyStimulus(row, 10);

        $display("[TB] random rows");
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
            if (r % 4 == 0) row[int'($urandom_range(8, 15))*32 +: 32] = row[int'($urandom_range(0, 7))*32 +: 32];
            applyStimulus(row, int'($urandom_range(0, 3)));
        end

        $display("[TB] start held high");
        n0 = n_acc;
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
        out_ready = 1'b1;
        scaled_score = row;
        start = 1'b1;
        sb.push_back(refModel(row));
        repeat (40) @(posedge clk);
        #1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held_start_count", 32'(n_acc - n0), 32'd1);
        checkOutput("held_start_overrun", 32'(overrun), 32'd0);

        $display("[TB] overrun during HOLD");
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
        scaled_score = row;
        start = 1'b1;
        sb.push_back(refModel(row));
        @(posedge clk);
        #1;
        start = 1'b0;
        waitValid(cyc);
        checkOutput("overrun_latency", 32'(cyc), 32'(LANES - 1));
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
        scaled_score = row;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        $display("[TB] start coincident with handshake");
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
        scaled_score = row;
        start = 1'b1;
        sb.push_back(refModel(row));
        @(posedge clk);
        #1;
        start = 1'b0;
        waitValid(cyc);
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
        scaled_score = row;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checkOutput("coincident_dropped", 32'(out_valid), 32'd0);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        $display("[TB] reset mid-scan");
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = intToFp(LANES - i);
        scaled_score = row;
        start = 1'b1;
        sb.push_back(refModel(row));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_max", max_score, 32'd0);
        checkOutput("midrst_idx", 32'(max_idx), 32'd0);
        checkOutput("midrst_overrun", 32'(overrun), 32'd0);
        checkRow("midrst_score", score_out, '0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < LANES; i++) row[i*32 +: 32] = randLane();
        applyStimulus(row, 2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
